sort_array_ctrl: RTL

- Sequencer for a linear array of PE_NUM two-value sort PEs doing block odd-even transposition sort over 2*PE_NUM values.
- Accepts input pairs on a valid/ready stream and distributes them to PEs via one-hot write enables.
- Drives per-PE receive_right / sort_en / send_right / receive_left for PE_NUM alternating even/odd phases, then pulses done.
- Result collection from the PE `out` buses is outside this block.

---
 rtl/sort_array_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sort_array_ctrl.sv
// Sequencer for a linear array of two-value sort PEs running block odd-even
// transposition sort: loads PE_NUM pairs, then runs PE_NUM compare/exchange phases.
module sort_array_ctrl #(
    parameter int unsigned FIX_POINT_WIDTH = 16,
    parameter int unsigned PE_NUM          = 4,
    parameter int unsigned SORT_LAT        = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FIX_POINT_WIDTH-1:0]    in_data1,
    input  logic [FIX_POINT_WIDTH-1:0]    in_data2,
    output logic [PE_NUM-1:0]             write_enable,
    output logic [FIX_POINT_WIDTH-1:0]    write_data1,
    output logic [FIX_POINT_WIDTH-1:0]    write_data2,
    output logic [PE_NUM-1:0]             receive_right,
    output logic [PE_NUM-1:0]             sort_en,
    output logic [PE_NUM-1:0]             send_right,
    output logic [PE_NUM-1:0]             receive_left,
    output logic                          busy,
    output logic [$clog2(PE_NUM+1)-1:0]   phase,
    output logic                          done
);

    localparam int unsigned PW = $clog2(PE_NUM + 1);
    localparam int unsigned CW = $clog2(SORT_LAT + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_XFER,
        S_SORT,
        S_RET,
        S_DONE
    } state_t;

    state_t                      state, state_nxt;
    logic [PW-1:0]               load_cnt, load_cnt_nxt;
    logic [PW-1:0]               phase_cnt, phase_cnt_nxt;
    logic [CW-1:0]               sort_cnt, sort_cnt_nxt;
    logic [PE_NUM-1:0]           left_mask;
    logic                        accept;

    logic                        in_ready_nxt, busy_nxt, done_nxt;
    logic [PE_NUM-1:0]           write_enable_nxt, receive_right_nxt, sort_en_nxt;
    logic [PE_NUM-1:0]           send_right_nxt, receive_left_nxt;
    logic [FIX_POINT_WIDTH-1:0]  write_data1_nxt, write_data2_nxt;

    assign accept = in_valid & in_ready;

    // Left PEs of the current phase: parity matches phase, and a right partner exists.
    always_comb begin
        left_mask = '0;
        for (int i = 0; i < int'(PE_NUM) - 1; i++) begin
            if ((i % 2) == int'(phase_cnt[0])) begin
                left_mask[i] = 1'b1;
            end
        end
    end

    // Next state; strobes are decoded from the current state and registered,
    // so each strobe appears the cycle after its state is entered.
    always_comb begin
        state_nxt         = state;
        load_cnt_nxt      = load_cnt;
        phase_cnt_nxt     = phase_cnt;
        sort_cnt_nxt      = sort_cnt;
        write_enable_nxt  = '0;
        receive_right_nxt = '0;
        sort_en_nxt       = '0;
        send_right_nxt    = '0;
        receive_left_nxt  = '0;
        done_nxt          = 1'b0;
        write_data1_nxt   = write_data1;
        write_data2_nxt   = write_data2;

        case (state)
            S_LOAD: begin
                if (accept) begin
                    write_enable_nxt = PE_NUM'(1) << load_cnt;
                    write_data1_nxt  = in_data1;
                    write_data2_nxt  = in_data2;
                    load_cnt_nxt     = load_cnt + PW'(1);
                    if (load_cnt == PW'(PE_NUM - 1)) begin
                        state_nxt     = S_XFER;
                        phase_cnt_nxt = '0;
                    end
                end
            end
            S_XFER: begin
                receive_right_nxt = left_mask;
                sort_cnt_nxt      = '0;
                state_nxt         = S_SORT;
            end
            S_SORT: begin
                sort_en_nxt = left_mask;
                if (sort_cnt == CW'(SORT_LAT - 1)) begin
                    state_nxt = S_RET;
                end else begin
                    sort_cnt_nxt = sort_cnt + CW'(1);
                end
            end
            S_RET: begin
                send_right_nxt   = left_mask;
                receive_left_nxt = left_mask << 1;
                if (phase_cnt == PW'(PE_NUM - 1)) begin
                    phase_cnt_nxt = '0;
                    state_nxt     = S_DONE;
                end else begin
                    phase_cnt_nxt = phase_cnt + PW'(1);
                    state_nxt     = S_XFER;
                end
            end
            S_DONE: begin
                done_nxt      = 1'b1;
                load_cnt_nxt  = '0;
                phase_cnt_nxt = '0;
                state_nxt     = S_LOAD;
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase

        in_ready_nxt = (state_nxt == S_LOAD);
        busy_nxt     = (state == S_XFER) || (state == S_SORT) || (state == S_RET) ||
                       ((state == S_LOAD) && (state_nxt == S_XFER));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_LOAD;
            load_cnt      <= '0;
            phase_cnt     <= '0;
            sort_cnt      <= '0;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            phase         <= '0;
            write_enable  <= '0;
            receive_right <= '0;
            sort_en       <= '0;
            send_right    <= '0;
            receive_left  <= '0;
            write_data1   <= '0;
            write_data2   <= '0;
        end else begin
            state         <= state_nxt;
            load_cnt      <= load_cnt_nxt;
            phase_cnt     <= phase_cnt_nxt;
            sort_cnt      <= sort_cnt_nxt;
            in_ready      <= in_ready_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            phase         <= phase_cnt;
            write_enable  <= write_enable_nxt;
            receive_right <= receive_right_nxt;
            sort_en       <= sort_en_nxt;
            send_right    <= send_right_nxt;
            receive_left  <= receive_left_nxt;
            write_data1   <= write_data1_nxt;
            write_data2   <= write_data2_nxt;
        end
    end

endmodule
